rob_tag_issuer: RTL and testbench



---
 rtl/rob_tag_issuer_pkg.sv | 20 ++
 rtl/rob_tag_issuer_id_table.sv | 56 +++++
 rtl/rob_tag_issuer.sv | 94 +++++++++
 tb/tb_rob_tag_issuer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rob_tag_issuer_pkg.sv
// Shared widths, output-stage states and the issuer->tag-compare request type
// for the read-path front end.
package rob_tag_issuer_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int TID_WIDTH      = 4;
    localparam int FIFO_SIZE      = 8;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    typedef struct packed {
        logic [TID_WIDTH-1:0]      tid;
        logic [AXI_ADDR_WIDTH-1:0] addr;
    } tagged_req_t;

endpackage

// File: rtl/rob_tag_issuer_id_table.sv
// Circular FIFO of AXI IDs in issue order; the head is read combinationally so
// the response side can drive rid without a pipeline bubble.
module rob_tag_issuer_id_table #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty table is ignored; the owner flags it as an error.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rob_tag_issuer.sv
// Stamps accepted AXI read-address requests with sequential tIDs (starting at 1),
// forwards them through a one-entry output register and bounds reads in flight.
module rob_tag_issuer #(
    parameter int ADDR_WIDTH = rob_tag_issuer_pkg::AXI_ADDR_WIDTH,
    parameter int ID_WIDTH   = rob_tag_issuer_pkg::AXI_ID_WIDTH,
    parameter int TID_WIDTH  = rob_tag_issuer_pkg::TID_WIDTH,
    parameter int MAX_OUTST  = rob_tag_issuer_pkg::FIFO_SIZE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arvalid_i,
    output logic                           arready_o,
    input  logic [ID_WIDTH-1:0]            arid_i,
    input  logic [ADDR_WIDTH-1:0]          araddr_i,
    output logic                           req_valid_o,
    input  logic                           req_ready_i,
    output logic [TID_WIDTH-1:0]           req_tid_o,
    output logic [ADDR_WIDTH-1:0]          req_addr_o,
    input  logic                           retire_i,
    output logic [ID_WIDTH-1:0]            retire_rid_o,
    output logic [$clog2(MAX_OUTST):0]     outst_o,
    output logic                           err_o
);

    import rob_tag_issuer_pkg::*;

    localparam int OUTST_W = $clog2(MAX_OUTST) + 1;

    out_state_e           state;
    out_state_e           state_nxt;
    logic                 accept;
    logic                 has_room;
    logic [TID_WIDTH-1:0] tid_cnt;

    // Ready depends only on the registered count and the downstream ready,
    // so a retire in the same cycle cannot reopen a full window.
    assign has_room    = (outst_o < OUTST_W'(MAX_OUTST));
    assign arready_o   = !rst && ((state == OUT_EMPTY) || req_ready_i) && has_room;
    assign accept      = arvalid_i && arready_o;
    assign req_valid_o = (state == OUT_FULL);

    always_comb begin
        state_nxt = state;
        case (state)
            OUT_EMPTY: if (accept) state_nxt = OUT_FULL;
            OUT_FULL:  if (req_ready_i && !accept) state_nxt = OUT_EMPTY;
            default:   state_nxt = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_tid_o  <= '0;
            req_addr_o <= '0;
            tid_cnt    <= TID_WIDTH'(1);
        end else if (accept) begin
            req_tid_o  <= tid_cnt;
            req_addr_o <= araddr_i;
            tid_cnt    <= tid_cnt + TID_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (retire_i && (outst_o == '0)) begin
            err_o <= 1'b1;
        end
    end

    // The table's occupancy doubles as the outstanding-read count.
    rob_tag_issuer_id_table #(
        .DEPTH (MAX_OUTST),
        .WIDTH (ID_WIDTH),
        .CNT_W (OUTST_W)
    ) u_id_table (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (arid_i),
        .pop       (retire_i),
        .head      (retire_rid_o),
        .count     (outst_o)
    );

endmodule

// File: tb/tb_rob_tag_issuer.sv
// Directed and randomized bench for rob_tag_issuer against a queue-based model.
module tb_rob_tag_issuer;

    localparam int AW        = 32;
    localparam int IW        = 4;
    localparam int TW        = 4;
    localparam int MAXO      = 8;
    localparam int TID_SPACE = 1 << TW;

    logic          clk = 1'b0;
    logic          rst;
    logic          arvalid;
    logic          arready;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic          req_valid;
    logic          req_ready;
    logic [TW-1:0] req_tid;
    logic [AW-1:0] req_addr;
    logic          retire;
    logic [IW-1:0] retire_rid;
    logic [3:0]    outst;
    logic          err;

    rob_tag_issuer #(
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .TID_WIDTH  (TW),
        .MAX_OUTST  (MAXO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arvalid_i    (arvalid),
        .arready_o    (arready),
        .arid_i       (arid),
        .araddr_i     (araddr),
        .req_valid_o  (req_valid),
        .req_ready_i  (req_ready),
        .req_tid_o    (req_tid),
        .req_addr_o   (req_addr),
        .retire_i     (retire),
        .retire_rid_o (retire_rid),
        .outst_o      (outst),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: issued-but-unretired IDs kept as a plain queue.
    int            next_tid;
    bit            m_valid;
    int            m_tid;
    logic [AW-1:0] m_addr;
    logic [IW-1:0] id_q [$];
    bit            m_err;
    int            accept_count;

    task automatic modelReset();
        next_tid = 1;
        m_valid  = 0;
        m_tid    = 0;
        m_addr   = '0;
        id_q.delete();
        m_err    = 0;
    endtask

    function automatic bit expReady();
        return !rst && (!m_valid || req_ready) && (id_q.size() < MAXO);
    endfunction

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("arready", 64'(arready), 64'(expReady()));
        checkValue("req_valid", 64'(req_valid), 64'(m_valid));
        checkValue("req_tid", 64'(req_tid), 64'(m_tid));
        checkValue("req_addr", 64'(req_addr), 64'(m_addr));
        checkValue("outst", 64'(outst), 64'(id_q.size()));
        checkValue("err", 64'(err), 64'(m_err));
        if (id_q.size() > 0) begin
            checkValue("retire_rid", 64'(retire_rid), 64'(id_q[0]));
        end
    endtask

    task automatic applyStimulus(input bit av, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                 input bit rr, input bit ret);
        bit acc;
        @(negedge clk);
        arvalid   = av;
        arid      = id;
        araddr    = addr;
        req_ready = rr;
        retire    = ret;
        #1;
        checkOutput();
        acc = av && expReady();
        @(posedge clk);
        if (m_valid && rr && !acc) m_valid = 0;
        if (ret) begin
            if (id_q.size() > 0) void'(id_q.pop_front());
            else m_err = 1;
        end
        if (acc) begin
            m_valid  = 1;
            m_tid    = next_tid;
            m_addr   = addr;
            next_tid = (next_tid + 1) % TID_SPACE;
            id_q.push_back(id);
            accept_count++;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        arvalid   = 1'b1;
        req_ready = 1'b1;
        retire    = 1'b0;
        modelReset();
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        rst     = 1'b0;
        arvalid = 1'b0;
    endtask

    initial begin
        int start;
        rst          = 1'b0;
        arvalid      = 1'b0;
        arid         = '0;
        araddr       = '0;
        req_ready    = 1'b1;
        retire       = 1'b0;
        accept_count = 0;
        modelReset();

        $display("[TB] reset and single request");
        doReset();
        applyStimulus(1, 4'd3, 32'h100, 1, 0);
        applyStimulus(0, 4'd0, 32'h0, 1, 0);
        applyStimulus(0, 4'd0, 32'h0, 1, 1);
        applyStimulus(0, 4'd0, 32'h0, 1, 0);

        $display("[TB] eight back-to-back requests fill the window");
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, IW'(i), 32'h1000 + 32'(i * 4), 1, 0);
        applyStimulus(1, 4'd9, 32'h2000, 1, 1);
        applyStimulus(0, 4'd0, 32'h0, 1, 0);
        applyStimulus(1, 4'd9, 32'h2000, 1, 0);

        $display("[TB] downstream stall holds the output register");
        doReset();
        applyStimulus(1, 4'd5, 32'hA000, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 4'd6, 32'hB000, 0, 0);
        applyStimulus(1, 4'd6, 32'hB000, 1, 0);
        applyStimulus(0, 4'd0, 32'h0, 1, 1);
        applyStimulus(0, 4'd0, 32'h0, 1, 1);
        applyStimulus(0, 4'd0, 32'h0, 1, 0);

        $display("[TB] tID wrap over seventeen requests");
        doReset();
        start = accept_count;
        for (int i = 0; i < 80 && (accept_count - start) < 17; i++) begin
            applyStimulus(1, IW'(i), $urandom, 1, (i % 2 == 1) && (id_q.size() > 0));
        end
        checkValue("wrap_accepts", 64'(accept_count - start), 64'd17);
        while (id_q.size() > 0) applyStimulus(0, 4'd0, 32'h0, 1, 1);
        applyStimulus(0, 4'd0, 32'h0, 1, 0);

        $display("[TB] retire underflow and mid-burst reset");
        doReset();
        applyStimulus(0, 4'd0, 32'h0, 1, 1);
        applyStimulus(0, 4'd0, 32'h0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, IW'(i + 2), $urandom, 1, 0);
        doReset();
        applyStimulus(1, 4'd9, 32'h55, 1, 0);
        applyStimulus(0, 4'd0, 32'h0, 1, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset();
            applyStimulus($urandom_range(0, 3) != 0, IW'($urandom), $urandom,
                          $urandom_range(0, 3) != 0,
                          (id_q.size() > 0) && ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
